// File: rtl/data_mem_responder_pkg.sv
// Shared widths, state decode and request payload for the memory responder.
package data_mem_responder_pkg;

   localparam int unsigned MEM_ADDR_W = 32;
   localparam int unsigned MEM_DATA_W = 32;
   localparam int unsigned MEM_BE_W   = 4;
   localparam int unsigned MEM_BYTE_W = 8;
   localparam int unsigned MEM_CNT_W  = 4;

   // Debug view of the response counter
   typedef enum logic [1:0] {
      MEM_IDLE,
      MEM_WAIT,
      MEM_RESP
   } mem_resp_state_e;

   // One core request as presented on the req/gnt interface
   typedef struct packed {
      logic [MEM_ADDR_W-1:0] addr;
      logic                  we;
      logic [MEM_BE_W-1:0]   be;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_req_t;

   // Map the response counter onto its named state
   function automatic mem_resp_state_e decode_cnt(input logic [MEM_CNT_W-1:0] cnt);
      mem_resp_state_e st;
      if (cnt == MEM_CNT_W'(0)) begin
         st = MEM_IDLE;
      end else if (cnt == MEM_CNT_W'(1)) begin
         st = MEM_RESP;
      end else begin
         st = MEM_WAIT;
      end
      return st;
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-organised storage with byte-enabled synchronous write and registered read.
module mem_word_array
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned WORDS = 64,
   parameter int unsigned IDX_W = 6
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [IDX_W-1:0]      idx,
   input  logic [MEM_BE_W-1:0]   be,
   input  logic [MEM_DATA_W-1:0] wdata,
   output logic [MEM_DATA_W-1:0] rdata
);

   // Contents are never reset; callers only read words they have written
   logic [MEM_DATA_W-1:0] mem [WORDS];

   // Byte-lane write, one access per cycle
   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int b = 0; b < int'(MEM_BE_W); b++) begin
            if (be[b]) begin
               mem[idx][b*MEM_BYTE_W +: MEM_BYTE_W] <= wdata[b*MEM_BYTE_W +: MEM_BYTE_W];
            end
         end
      end
   end

   // Read word is captured and held until the next read access
   always_ff @(posedge clk) begin
      if (en && !we) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for a req/gnt/rvalid port with fixed grant-to-response latency.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 256,
   parameter int unsigned LATENCY   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_i,
   input  logic [MEM_ADDR_W-1:0] addr_i,
   input  logic                  we_i,
   input  logic [MEM_BE_W-1:0]   be_i,
   input  logic [MEM_DATA_W-1:0] wdata_i,
   output logic                  gnt_o,
   output logic                  rvalid_o,
   output logic [MEM_DATA_W-1:0] rdata_o,
   output logic                  err_o
);

   localparam int unsigned WORDS = MEM_BYTES / 4;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   mem_req_t              req;
   mem_resp_state_e       state;
   logic [MEM_CNT_W-1:0]  cnt;
   logic [MEM_CNT_W-1:0]  cnt_d;
   logic                  err_q;
   logic                  err_d;
   logic                  rd_q;
   logic                  rd_d;
   logic                  grant;
   logic                  in_range;
   logic [IDX_W-1:0]      idx;
   logic [MEM_DATA_W-1:0] arr_rdata;

   // Pack the request fields and derive address decode
   assign req      = '{addr: addr_i, we: we_i, be: be_i, wdata: wdata_i};
   assign in_range = (req.addr < MEM_ADDR_W'(MEM_BYTES));
   assign idx      = req.addr[IDX_W+1:2];
   assign state    = decode_cnt(cnt);

   // Accept in IDLE or in the RESP cycle of the previous request
   assign grant = req_i && !rst && (state != MEM_WAIT);

   // Next-state: reload counter on grant, otherwise count down to idle
   always_comb begin
      cnt_d = cnt;
      err_d = err_q;
      rd_d  = rd_q;
      if (grant) begin
         cnt_d = MEM_CNT_W'(LATENCY);
         err_d = !in_range;
         rd_d  = !req.we;
      end else if (state != MEM_IDLE) begin
         cnt_d = cnt - MEM_CNT_W'(1);
      end
   end

   // Counter and response-kind registers; reset drops any pending response
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         err_q <= 1'b0;
         rd_q  <= 1'b0;
      end else begin
         cnt   <= cnt_d;
         err_q <= err_d;
         rd_q  <= rd_d;
      end
   end

   mem_word_array #(
      .WORDS (WORDS),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (grant && in_range),
      .we    (req.we),
      .idx   (idx),
      .be    (req.be),
      .wdata (req.wdata),
      .rdata (arr_rdata)
   );

   // Response outputs are zero outside the response cycle
   assign gnt_o    = grant;
   assign rvalid_o = (state == MEM_RESP);
   assign err_o    = rvalid_o && err_q;
   assign rdata_o  = (rvalid_o && rd_q && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at latencies 1, 3 and 4 with a response scoreboard.
module tb_data_mem_responder;

   typedef struct {
      int          inst;
      int          due;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic [2:0]  rst;
   logic [2:0]  req;
   logic [2:0]  we;
   logic [2:0]  gnt;
   logic [2:0]  rvalid;
   logic [2:0]  err;
   logic [31:0] addr  [3];
   logic [3:0]  be    [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];

   exp_t        sb [$];
   logic [7:0]  mdl [3][256];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_responder #(.MEM_BYTES(256), .LATENCY(1)) u_l1 (
      .clk(clk), .rst(rst[0]), .req_i(req[0]), .addr_i(addr[0]), .we_i(we[0]),
      .be_i(be[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
      .rdata_o(rdata[0]), .err_o(err[0]));

   data_mem_responder #(.MEM_BYTES(256), .LATENCY(3)) u_l3 (
      .clk(clk), .rst(rst[1]), .req_i(req[1]), .addr_i(addr[1]), .we_i(we[1]),
      .be_i(be[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
      .rdata_o(rdata[1]), .err_o(err[1]));

   data_mem_responder #(.MEM_BYTES(256), .LATENCY(4)) u_l4 (
      .clk(clk), .rst(rst[2]), .req_i(req[2]), .addr_i(addr[2]), .we_i(we[2]),
      .be_i(be[2]), .wdata_i(wdata[2]), .gnt_o(gnt[2]), .rvalid_o(rvalid[2]),
      .rdata_o(rdata[2]), .err_o(err[2]));

   function automatic int lat(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one request, wait for its grant, and log the expected response
   task automatic issue(input int i, input logic w, input logic [31:0] a,
                        input logic [3:0] bmask, input logic [31:0] d, output int waited);
      exp_t        e;
      logic        got;
      logic [31:0] base;
      req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = bmask; wdata[i] = d;
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 40) begin
         @(negedge clk);
         if (gnt[i]) got = 1'b1;
         else waited++;
      end
      if (!got) begin
         chk($sformatf("gnt_timeout%0d", i), 32'(gnt[i]), 32'd1);
      end else begin
         base    = {a[31:2], 2'b00};
         e.inst  = i;
         e.due   = cyc + lat(i);
         e.err   = (a >= 32'd256);
         e.rdata = '0;
         if (!e.err) begin
            if (w) begin
               for (int k = 0; k < 4; k++)
                  if (bmask[k]) mdl[i][int'(base[7:0]) + k] = d[k*8 +: 8];
            end else begin
               e.rdata = {mdl[i][int'(base[7:0]) + 3], mdl[i][int'(base[7:0]) + 2],
                          mdl[i][int'(base[7:0]) + 1], mdl[i][int'(base[7:0])]};
            end
         end
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      req[i] = 1'b0;
   endtask

   // Response monitor: every cycle, every instance
   logic mon_v;
   exp_t mon_e;
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         mon_v = (sb.size() > 0) && (sb[0].inst == i) && (sb[0].due == cyc);
         chk($sformatf("rvalid%0d@%0d", i, cyc), 32'(rvalid[i]), 32'(mon_v));
         if (mon_v) begin
            mon_e = sb.pop_front();
            chk($sformatf("rdata%0d@%0d", i, cyc), rdata[i], mon_e.rdata);
            chk($sformatf("err%0d@%0d", i, cyc), 32'(err[i]), 32'(mon_e.err));
         end else begin
            chk($sformatf("idle_rdata%0d@%0d", i, cyc), rdata[i], 32'd0);
            chk($sformatf("idle_err%0d@%0d", i, cyc), 32'(err[i]), 32'd0);
         end
      end
   end

   int          w;
   logic [31:0] val;

   initial begin
      rst = 3'b111; req = 3'b000; we = 3'b000;
      for (int i = 0; i < 3; i++) begin
         addr[i] = '0; be[i] = '0; wdata[i] = '0;
      end

      // Reset: grant suppressed even with a request pending
      repeat (3) @(posedge clk);
      #1 req = 3'b111;
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk($sformatf("rst_gnt%0d", i), 32'(gnt[i]), 32'd0);
      chk("rst_cnt", 32'(u_l1.cnt), 32'd0);
      @(posedge clk);
      #1 rst = 3'b000; req = 3'b000;
      @(posedge clk);
      #1;

      // LATENCY=1: full write then read back
      issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, w);
      chk("l1_wr_wait", 32'(w), 32'd0);
      issue(0, 1'b0, 32'h10, 4'h0, 32'h0, w);
      chk("l1_rd_wait", 32'(w), 32'd0);

      // Partial write of lane 1, then read
      issue(0, 1'b1, 32'h12, 4'b0010, 32'h0000AA00, w);
      issue(0, 1'b0, 32'h10, 4'h0, 32'h0, w);
      // Zero byte enables still respond but change nothing
      issue(0, 1'b1, 32'h10, 4'h0, 32'h11223344, w);
      issue(0, 1'b0, 32'h10, 4'h0, 32'h0, w);

      // Fill words 0..3, then four back-to-back reads
      for (int k = 0; k < 4; k++) begin
         val = $urandom;
         issue(0, 1'b1, 32'(k * 4), 4'hF, val, w);
      end
      for (int k = 0; k < 4; k++) begin
         issue(0, 1'b0, 32'(k * 4), 4'h0, 32'h0, w);
         chk($sformatf("b2b_gnt%0d", k), 32'(w), 32'd0);
      end

      // Out-of-range accesses, then confirm word 0 untouched
      issue(0, 1'b0, 32'h100, 4'h0, 32'h0, w);
      issue(0, 1'b1, 32'h100, 4'hF, 32'h12345678, w);
      issue(0, 1'b1, 32'hFFFFFFFC, 4'hF, 32'h87654321, w);
      issue(0, 1'b0, 32'h0, 4'h0, 32'h0, w);
      issue(0, 1'b0, 32'hFC, 4'h0, 32'h0, w);
      repeat (3) @(posedge clk);
      #1;

      // LATENCY=3: held requests granted every third cycle, read-after-write
      issue(1, 1'b1, 32'h20, 4'hF, 32'hA5A55A5A, w);
      chk("l3_first_wait", 32'(w), 32'd0);
      issue(1, 1'b0, 32'h20, 4'h0, 32'h0, w);
      chk("l3_second_wait", 32'(w), 32'd2);
      issue(1, 1'b1, 32'h21, 4'b1001, 32'h01FFFF02, w);
      chk("l3_third_wait", 32'(w), 32'd2);
      issue(1, 1'b0, 32'h20, 4'h0, 32'h0, w);
      repeat (5) @(posedge clk);
      #1;

      // LATENCY=4: reset two cycles after a read grant drops its response
      issue(2, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, w);
      issue(2, 1'b0, 32'h40, 4'h0, 32'h0, w);
      chk("l4_rd_wait", 32'(w), 32'd3);
      @(posedge clk);
      #1 rst[2] = 1'b1; req[2] = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("l4_rst_gnt_pre", 32'(gnt[2]), 32'd0);
      @(posedge clk);
      #1;
      chk("l4_rst_cnt", 32'(u_l4.cnt), 32'd0);
      chk("l4_rst_gnt", 32'(gnt[2]), 32'd0);
      chk("l4_rst_rvalid", 32'(rvalid[2]), 32'd0);
      @(posedge clk);
      #1 rst[2] = 1'b0; req[2] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      issue(2, 1'b0, 32'h40, 4'h0, 32'h0, w);
      chk("l4_post_rst_wait", 32'(w), 32'd0);

      repeat (8) @(posedge clk);
      #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
